rv_muldiv: RTL

- Parametrised iterative multiply/divide unit implementing the RV32M funct3 set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for operands of XLEN bits.
- Sits beside the ULA in the EX stage; the core stalls IF/ID/ID_EX while busy is high.
- Adds multi-cycle execution, a start/busy/done handshake, flush-abort and RISC-V divide special cases, none of which the single-cycle ULA path provides.

---
 rtl/rv_muldiv.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a start/busy/done handshake and flush abort.
module rv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [2*XLEN-1:0] acc_r, acc_nxt_s, prod_s;
  logic [XLEN-1:0]   opnd_r;
  logic              neg_r;
  logic [2:0]        funct3_r;
  logic [4:0]        rd_r;

  logic              accept_s, special_s, last_step_s, calc_step_s;
  logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, special_val_s, final_s;
  logic [XLEN:0]     sum_s, shl_s, diff_s;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
    return {(2*XLEN){1'b0}} - v;
  endfunction

  // Operand sign handling and the divide special cases, decoded from the live inputs
  always_comb begin
    a_signed_s = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed_s = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg_s    = a_signed_s && op_a[XLEN-1];
    b_neg_s    = b_signed_s && op_b[XLEN-1];
    a_mag_s    = a_neg_s ? f_neg(op_a) : op_a;
    b_mag_s    = b_neg_s ? f_neg(op_b) : op_b;
    if (funct3 == F_REM) begin
      neg_s = a_neg_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    special_s = funct3[2] && ((op_b == {XLEN{1'b0}}) ||
                (!funct3[0] && (op_a == MIN_NEG) && (op_b == {XLEN{1'b1}})));
    case (funct3)
      F_DIV, F_DIVU: special_val_s = (op_b == {XLEN{1'b0}}) ? {XLEN{1'b1}} : op_a;
      F_REM, F_REMU: special_val_s = (op_b == {XLEN{1'b0}}) ? op_a : {XLEN{1'b0}};
      default:       special_val_s = {XLEN{1'b0}};
    endcase
  end

  assign accept_s    = enable && start && !flush &&
                       ((state_r == S_IDLE) || (state_r == S_DONE));
  assign calc_step_s = enable && !flush && (state_r == S_CALC);
  assign last_step_s = calc_step_s && (cnt_r == CW'(XLEN-1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; enable low freezes, flush always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = state_r;
    end else if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt_s = special_s ? S_DONE : S_CALC;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_CALC: begin
          if (cnt_r == CW'(XLEN-1)) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_CALC;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state_r == S_CALC) begin
      busy = 1'b1;
    end else if (state_r == S_DONE) begin
      done = 1'b1;
    end else begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  // One radix-2 step; acc holds {hi, lo} = {partial/remainder, multiplier/quotient}
  always_comb begin
    sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
             (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    shl_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s = shl_s - {1'b0, opnd_r};
    if (funct3_r[2]) begin
      if (!diff_s[XLEN]) begin
        acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Final sign fix-up and result selection from the last step's accumulator
  always_comb begin
    prod_s = neg_r ? f_neg2(acc_nxt_s) : acc_nxt_s;
    case (funct3_r)
      F_MUL:                      final_s = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  final_s = prod_s[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              final_s = neg_r ? f_neg(acc_nxt_s[XLEN-1:0])
                                                  : acc_nxt_s[XLEN-1:0];
      F_REM, F_REMU:              final_s = neg_r ? f_neg(acc_nxt_s[2*XLEN-1:XLEN])
                                                  : acc_nxt_s[2*XLEN-1:XLEN];
      default:                    final_s = {XLEN{1'b0}};
    endcase
  end

  // Operand latch at accept and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_r <= 3'b000;
      rd_r     <= 5'd0;
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      opnd_r   <= {XLEN{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
    end else if (accept_s) begin
      funct3_r <= funct3;
      rd_r     <= rd_in;
      cnt_r    <= {CW{1'b0}};
      neg_r    <= neg_s;
      if (funct3[2]) begin
        opnd_r <= b_mag_s;
        acc_r  <= {{XLEN{1'b0}}, a_mag_s};
      end else begin
        opnd_r <= a_mag_s;
        acc_r  <= {{XLEN{1'b0}}, b_mag_s};
      end
    end else if (calc_step_s) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // result/rd_out update only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= {XLEN{1'b0}};
      rd_out <= 5'd0;
    end else if (accept_s && special_s) begin
      result <= special_val_s;
      rd_out <= rd_in;
    end else if (last_step_s) begin
      result <= final_s;
      rd_out <= rd_r;
    end
  end

endmodule
